// File: rtl/axis_box_filter_stream.sv
// axis_box_filter_stream: streaming KxK box (mean) filter over a raster-order
// AXI-Stream image. The window is causal and anchored at its bottom-right
// corner. Three register stages are followed by a 2-entry skid FIFO.
module axis_box_filter_stream #(
    parameter int R_I         = 5,
    parameter int C_I         = 5,
    parameter int W_I         = 8,
    parameter int K           = 3,
    parameter int BORDER_MODE = 0,
    parameter int ROUND       = 0
) (
    input  logic           clk,
    input  logic           rstn,
    output logic           s_axis_box_ready,
    input  logic           s_axis_box_valid,
    input  logic [W_I-1:0] s_axis_box_data,
    input  logic           s_axis_box_user,
    input  logic           s_axis_box_last,
    input  logic           m_axis_box_ready,
    output logic           m_axis_box_valid,
    output logic [W_I-1:0] m_axis_box_data,
    output logic           m_axis_box_user,
    output logic           m_axis_box_last
);
    localparam int KK = K * K;
    localparam int SW = W_I + $clog2(KK);
    localparam int RW = $clog2(R_I);
    localparam int CW = $clog2(C_I);

    typedef struct packed {
        logic           user;
        logic           last;
        logic [W_I-1:0] data;
    } beat_t;

    // Position is regenerated from the counters, so the incoming last flag has no role.
    logic unused_last;
    assign unused_last = s_axis_box_last;

    // Handshake / flow control
    logic          s_ready_q, s_ready_d;
    logic          s_fire, adv, push, pop;
    logic [1:0]    cnt_q, cnt_d;
    logic          wr_ptr_q, rd_ptr_q;
    beat_t         fifo_q [2];
    beat_t         head;

    // Stage 1: position, line buffers, window
    logic [RW-1:0] row_q, row_d, row_eff;
    logic [CW-1:0] col_q, col_d, col_eff;
    logic [W_I-1:0] lb_q    [K-1][C_I];
    logic [W_I-1:0] win_q   [K][K];
    logic [W_I-1:0] new_col [K];
    logic           s1_valid_q, s1_user_q, s1_last_q, s1_border_q;
    logic [W_I-1:0] s1_raw_q;

    // Stage 2: column sums
    logic [SW-1:0]  colsum_d [K];
    logic [SW-1:0]  colsum_q [K];
    logic           s2_valid_q, s2_user_q, s2_last_q, s2_border_q;
    logic [W_I-1:0] s2_raw_q;

    // Stage 3: total, divide, border select
    logic [SW-1:0]  total;
    logic [W_I-1:0] avg, s3_data_d;
    logic           s3_valid_q, s3_user_q, s3_last_q;
    logic [W_I-1:0] s3_data_q;

    assign s_axis_box_ready = s_ready_q;
    // A registered ready of 1 implies cnt_q < 2, hence adv is 1 in the same cycle.
    assign s_fire           = s_axis_box_valid && s_ready_q;

    // Skid FIFO bookkeeping: the pipeline moves only when the FIFO can take a beat.
    always_comb begin
        adv   = (cnt_q != 2'd2) || m_axis_box_ready;
        push  = adv && s3_valid_q;
        pop   = (cnt_q != 2'd0) && m_axis_box_ready;
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 2'd1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 2'd1;
        end
        s_ready_d = (cnt_d != 2'd2);
    end

    // Input position with start-of-frame resync, wrapping column then row.
    always_comb begin
        row_eff = s_axis_box_user ? '0 : row_q;
        col_eff = s_axis_box_user ? '0 : col_q;
        row_d   = row_q;
        col_d   = col_q;
        if (s_fire) begin
            if (col_eff == CW'(C_I - 1)) begin
                col_d = '0;
                row_d = (row_eff == RW'(R_I - 1)) ? '0 : row_eff + RW'(1);
            end else begin
                col_d = col_eff + CW'(1);
                row_d = row_eff;
            end
        end
    end

    // Column entering the window: current pixel on top, older rows from the line buffers.
    always_comb begin
        new_col[0] = s_axis_box_data;
        for (int j = 1; j < K; j++) begin
            new_col[j] = lb_q[j-1][col_eff];
        end
    end

    // Line buffers and window shift on every accepted beat; contents need no reset.
    always_ff @(posedge clk) begin
        if (s_fire) begin
            for (int j = 0; j < K - 1; j++) begin
                lb_q[j][col_eff] <= new_col[j];
            end
            for (int i = 0; i < K; i++) begin
                for (int k = 0; k < K - 1; k++) begin
                    win_q[i][k] <= win_q[i][k+1];
                end
                win_q[i][K-1] <= new_col[i];
            end
        end
    end

    // Stage 1 control: counters and per-beat sideband.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            row_q       <= '0;
            col_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_user_q   <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_border_q <= 1'b0;
            s1_raw_q    <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
            if (adv) begin
                s1_valid_q <= s_fire;
                if (s_fire) begin
                    s1_user_q   <= s_axis_box_user;
                    s1_last_q   <= (col_eff == CW'(C_I - 1));
                    s1_border_q <= (row_eff < RW'(K - 1)) || (col_eff < CW'(K - 1));
                    s1_raw_q    <= s_axis_box_data;
                end
            end
        end
    end

    // Vertical sums of each window column.
    always_comb begin
        for (int k = 0; k < K; k++) begin
            colsum_d[k] = '0;
            for (int i = 0; i < K; i++) begin
                colsum_d[k] = colsum_d[k] + SW'(win_q[i][k]);
            end
        end
    end

    // Stage 2 register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s2_valid_q  <= 1'b0;
            s2_user_q   <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_border_q <= 1'b0;
            s2_raw_q    <= '0;
            for (int k = 0; k < K; k++) begin
                colsum_q[k] <= '0;
            end
        end else if (adv) begin
            s2_valid_q  <= s1_valid_q;
            s2_user_q   <= s1_user_q;
            s2_last_q   <= s1_last_q;
            s2_border_q <= s1_border_q;
            s2_raw_q    <= s1_raw_q;
            for (int k = 0; k < K; k++) begin
                colsum_q[k] <= colsum_d[k];
            end
        end
    end

    // Window total, optional half-up rounding offset, constant divide, border select.
    always_comb begin
        total = SW'((ROUND != 0) ? (KK / 2) : 0);
        for (int k = 0; k < K; k++) begin
            total = total + colsum_q[k];
        end
        avg = W_I'(total / SW'(KK));
        if (!s2_border_q) begin
            s3_data_d = avg;
        end else if (BORDER_MODE != 0) begin
            s3_data_d = s2_raw_q;
        end else begin
            s3_data_d = '0;
        end
    end

    // Stage 3 register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s3_valid_q <= 1'b0;
            s3_user_q  <= 1'b0;
            s3_last_q  <= 1'b0;
            s3_data_q  <= '0;
        end else if (adv) begin
            s3_valid_q <= s2_valid_q;
            s3_user_q  <= s2_user_q;
            s3_last_q  <= s2_last_q;
            s3_data_q  <= s3_data_d;
        end
    end

    // Skid FIFO storage, pointers, occupancy and the registered input ready.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q     <= 2'd0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            s_ready_q <= 1'b1;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
        end else begin
            cnt_q     <= cnt_d;
            s_ready_q <= s_ready_d;
            if (push) begin
                fifo_q[wr_ptr_q] <= '{user: s3_user_q, last: s3_last_q, data: s3_data_q};
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    assign head             = fifo_q[rd_ptr_q];
    assign m_axis_box_valid = (cnt_q != 2'd0);
    assign m_axis_box_data  = head.data;
    assign m_axis_box_user  = head.user;
    assign m_axis_box_last  = head.last;

endmodule

// File: tb/tb_axis_box_filter_stream.sv
// Bench for axis_box_filter_stream: two instances (truncate/zero-border and
// round/raw-border) fed by one stream, checked against an image-based model.
module tb_axis_box_filter_stream;
    localparam int R = 5;
    localparam int C = 5;
    localparam int W = 8;
    localparam int K = 3;
    localparam int NPIX = R * C;

    logic clk = 1'b0;
    logic rstn;
    logic s_ready0, s_ready1, s_valid, s_user, s_last;
    logic [W-1:0] s_data;
    logic m_ready;
    logic m_valid0, m_valid1, m_user0, m_user1, m_last0, m_last1;
    logic [W-1:0] m_data0, m_data1;

    always #5 clk = ~clk;

    axis_box_filter_stream #(.R_I(R), .C_I(C), .W_I(W), .K(K), .BORDER_MODE(0), .ROUND(0)) dut0 (
        .clk(clk), .rstn(rstn),
        .s_axis_box_ready(s_ready0), .s_axis_box_valid(s_valid), .s_axis_box_data(s_data),
        .s_axis_box_user(s_user), .s_axis_box_last(s_last),
        .m_axis_box_ready(m_ready), .m_axis_box_valid(m_valid0), .m_axis_box_data(m_data0),
        .m_axis_box_user(m_user0), .m_axis_box_last(m_last0));

    axis_box_filter_stream #(.R_I(R), .C_I(C), .W_I(W), .K(K), .BORDER_MODE(1), .ROUND(1)) dut1 (
        .clk(clk), .rstn(rstn),
        .s_axis_box_ready(s_ready1), .s_axis_box_valid(s_valid), .s_axis_box_data(s_data),
        .s_axis_box_user(s_user), .s_axis_box_last(s_last),
        .m_axis_box_ready(m_ready), .m_axis_box_valid(m_valid1), .m_axis_box_data(m_data1),
        .m_axis_box_user(m_user1), .m_axis_box_last(m_last1));

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference model: the frame as a 2D image, position tracked per accepted pixel.
    typedef struct {int d0; int d1; bit u; bit l;} exp_t;
    typedef struct {logic [31:0] d0; logic [31:0] d1; logic u; logic l;} cap_t;
    exp_t q0[$];
    exp_t q1[$];
    cap_t cap[$];
    int img[R][C];
    int mr = 0;
    int mc = 0;

    task automatic model_accept(input int pix, input bit u);
        exp_t e;
        int s;
        if (u) begin
            mr = 0;
            mc = 0;
        end
        img[mr][mc] = pix;
        if (mr >= K - 1 && mc >= K - 1) begin
            s = 0;
            for (int i = 0; i < K; i++)
                for (int j = 0; j < K; j++)
                    s += img[mr-i][mc-j];
            e.d0 = s / (K * K);
            e.d1 = (s + (K * K) / 2) / (K * K);
        end else begin
            e.d0 = 0;
            e.d1 = pix;
        end
        e.u = u;
        e.l = (mc == C - 1);
        q0.push_back(e);
        q1.push_back(e);
        mc++;
        if (mc == C) begin
            mc = 0;
            mr++;
            if (mr == R) mr = 0;
        end
    endtask

    function automatic cap_t getcap(input int i);
        cap_t c;
        c = '{d0: 'x, d1: 'x, u: 1'bx, l: 1'bx};
        if (i < cap.size()) c = cap[i];
        return c;
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc++;

    int lat_arm = 0;
    int acc_cyc = 0;
    int lat_meas = -1;
    logic stall_q = 1'b0;
    logic [W-1:0] hd0, hd1;
    logic hu, hl;

    // Monitor: model update on input handshakes, scoreboard on output handshakes.
    always @(negedge clk) begin
        exp_t e;
        if (!rstn) begin
            stall_q = 1'b0;
        end else begin
            if (s_valid && s_ready0) begin
                chk("s_ready_pair", 32'(s_ready1), 32'(1));
                model_accept(int'(s_data), s_user);
                if (lat_arm == 1) begin
                    acc_cyc = cyc + 1;
                    lat_arm = 2;
                end
            end
            if (lat_arm == 2 && m_valid0) begin
                lat_meas = cyc - acc_cyc;
                lat_arm = 0;
            end
            if (stall_q) begin
                chk("hold_valid", 32'(m_valid0), 32'(1));
                chk("hold_data0", 32'(m_data0), 32'(hd0));
                chk("hold_data1", 32'(m_data1), 32'(hd1));
                chk("hold_user", 32'(m_user0), 32'(hu));
                chk("hold_last", 32'(m_last0), 32'(hl));
            end
            stall_q = m_valid0 && !m_ready;
            hd0 = m_data0;
            hd1 = m_data1;
            hu = m_user0;
            hl = m_last0;
            if (m_valid0 && m_ready) begin
                chk("beat0_pending", 32'(q0.size() != 0), 32'(1));
                if (q0.size() != 0) begin
                    e = q0.pop_front();
                    chk("data0", 32'(m_data0), 32'(e.d0));
                    chk("user0", 32'(m_user0), 32'(e.u));
                    chk("last0", 32'(m_last0), 32'(e.l));
                end
                cap.push_back('{d0: 32'(m_data0), d1: 32'(m_data1), u: m_user0, l: m_last0});
            end
            if (m_valid1 && m_ready) begin
                chk("beat1_pending", 32'(q1.size() != 0), 32'(1));
                if (q1.size() != 0) begin
                    e = q1.pop_front();
                    chk("data1", 32'(m_data1), 32'(e.d1));
                    chk("user1", 32'(m_user1), 32'(e.u));
                    chk("last1", 32'(m_last1), 32'(e.l));
                end
            end
        end
    end

    bit bp = 1'b0;
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic send_beat(input int d, input logic u, input bit gaps);
        int guard;
        int n;
        if (gaps) begin
            n = $urandom_range(0, 2);
            repeat (n) begin
                @(posedge clk);
                #1;
            end
        end
        s_valid = 1'b1;
        s_data = W'(d);
        s_user = u;
        s_last = 1'($urandom_range(0, 1));
        guard = 0;
        @(negedge clk);
        while (!s_ready0 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        chk("accept_wait", 32'(guard < 1000), 32'(1));
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_user = 1'b0;
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while ((q0.size() != 0 || q1.size() != 0) && g < 2000) begin
            @(posedge clk);
            g++;
        end
        #1;
        chk("drain_wait", 32'(g < 2000), 32'(1));
        repeat (4) begin
            @(posedge clk);
            #1;
        end
    endtask

    int rf[NPIX];
    logic [31:0] ref0[NPIX];
    int px[NPIX];
    int p7;

    initial begin
        rstn = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        s_user = 1'b0;
        s_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_ready", 32'(s_ready0), 32'(1));
        chk("rst_m_valid", 32'(m_valid0), 32'(0));
        chk("rst_m_data", 32'(m_data0), 32'(0));
        chk("rst_m_user", 32'(m_user0), 32'(0));
        chk("rst_m_last", 32'(m_last0), 32'(0));
        chk("rst_m_valid1", 32'(m_valid1), 32'(0));
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Constant frame of 9s, ready held high, latency measured.
        cap.delete();
        lat_arm = 1;
        for (int i = 0; i < NPIX; i++) send_beat(9, i == 0, 1'b0);
        wait_drain();
        chk("t1_latency", 32'(lat_meas), 32'(3));
        chk("t1_beats", 32'(cap.size()), 32'(NPIX));
        chk("t1_px00", getcap(0).d0, 32'(0));
        chk("t1_px21", getcap(11).d0, 32'(0));
        chk("t1_px22", getcap(12).d0, 32'(9));
        chk("t1_px44", getcap(24).d0, 32'(9));
        chk("t1_first_user", 32'(getcap(0).u), 32'(1));

        // Rounding: window at (2,2) sums to 14, window at (4,4) sums to 13.
        cap.delete();
        for (int i = 0; i < NPIX; i++) px[i] = 0;
        px[0] = 6;
        px[6] = 8;
        px[18] = 13;
        for (int i = 0; i < NPIX; i++) send_beat(px[i], i == 0, 1'b0);
        wait_drain();
        chk("t2_sum14_trunc", getcap(12).d0, 32'(1));
        chk("t2_sum14_round", getcap(12).d1, 32'(2));
        chk("t2_sum13_trunc", getcap(24).d0, 32'(1));
        chk("t2_sum13_round", getcap(24).d1, 32'(1));

        // Saturation: all pixels at full scale.
        cap.delete();
        for (int i = 0; i < NPIX; i++) send_beat(255, i == 0, 1'b0);
        wait_drain();
        chk("t3_sat_trunc", getcap(24).d0, 32'(255));
        chk("t3_sat_round", getcap(12).d1, 32'(255));

        // Random frame: reference run, then with backpressure and input gaps.
        for (int i = 0; i < NPIX; i++) rf[i] = $urandom_range(0, 255);
        cap.delete();
        for (int i = 0; i < NPIX; i++) send_beat(rf[i], i == 0, 1'b0);
        wait_drain();
        for (int i = 0; i < NPIX; i++) ref0[i] = getcap(i).d0;
        cap.delete();
        bp = 1'b1;
        for (int i = 0; i < NPIX; i++) send_beat(rf[i], i == 0, 1'b1);
        wait_drain();
        bp = 1'b0;
        chk("t4_beats", 32'(cap.size()), 32'(NPIX));
        for (int i = 0; i < NPIX; i++) begin
            chk("t4_same_as_ref", getcap(i).d0, ref0[i]);
            chk("t4_last_col", 32'(getcap(i).l), 32'((i % C) == C - 1));
        end

        // Resync: start-of-frame asserted on the 7th pixel.
        cap.delete();
        for (int i = 0; i < 6; i++) send_beat($urandom_range(0, 255), i == 0, 1'b0);
        p7 = $urandom_range(1, 255);
        send_beat(p7, 1'b1, 1'b0);
        for (int i = 1; i < NPIX; i++) send_beat($urandom_range(0, 255), 1'b0, 1'b0);
        wait_drain();
        chk("t5_resync_zero", getcap(6).d0, 32'(0));
        chk("t5_resync_user", 32'(getcap(6).u), 32'(1));
        chk("t5_resync_raw", getcap(6).d1, 32'(p7));
        chk("t5_beats", 32'(cap.size()), 32'(6 + NPIX));

        // Reset mid-frame after pixel 12.
        for (int i = 0; i < 12; i++) send_beat(9, i == 0, 1'b0);
        rstn = 1'b0;
        #1;
        chk("t6_valid_low", 32'(m_valid0), 32'(0));
        chk("t6_valid1_low", 32'(m_valid1), 32'(0));
        chk("t6_ready_high", 32'(s_ready0), 32'(1));
        q0.delete();
        q1.delete();
        cap.delete();
        mr = 0;
        mc = 0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("t6_no_stale", 32'(cap.size()), 32'(0));
        for (int i = 0; i < NPIX; i++) send_beat(9, 1'b0, 1'b0);
        wait_drain();
        chk("t6_beats", 32'(cap.size()), 32'(NPIX));
        chk("t6_px00", getcap(0).d0, 32'(0));
        chk("t6_px22", getcap(12).d0, 32'(9));
        chk("t6_px44", getcap(24).d0, 32'(9));
        chk("t6_px40", getcap(20).d0, 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
